program_loader: RTL and testbench

Boot-time instruction loader that sits directly upstream of the single-cycle MIPS processor and its word-addressed instruction memory. It receives a byte stream over a valid/ready handshake, checks a length header, assembles big-endian 32-bit words, and writes them sequentially into instruction memory. It holds the processor in reset until the image is fully written and its XOR checksum is verified.

---
 rtl/program_loader.sv | 172 +++++++++++++++++
 tb/tb_program_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader
//
// Boot-time loader for the single-cycle MIPS instruction memory. Accepts a
// byte stream (valid/ready), reads a 16-bit big-endian word count, assembles
// big-endian 32-bit words and writes them sequentially to instruction memory.
// A trailing XOR checksum byte gates release of the processor reset.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_byte  incoming stream byte
//   in_ready          loader can accept a byte (HDR0..CSUM, never during rst)
//   reload            pulse in DONE/ERROR restarts loading at HDR0
//   imem_we/addr/wdata  registered one-cycle word write to instruction memory
//   cpu_rst           processor reset, low only in DONE
//   done / error      load verified / length or checksum failure
module program_loader #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [15:0] DEPTH_16 = 16'(DEPTH);

    state_t              r_state;
    logic [15:0]         r_len;
    logic [7:0]          r_xor;
    logic [ADDR_W:0]     r_wcnt;     // one extra bit so N == DEPTH does not wrap
    logic [1:0]          r_bcnt;
    logic [31:0]         r_word;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_cpu_rst;
    logic                r_done;
    logic                r_error;

    logic                w_accept;
    logic [15:0]         w_len;
    logic                w_last_word;
    logic [31:0]         w_word;

    // Ready is combinational from state so it drops the instant rst rises.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            in_ready = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                       (r_state == S_DATA) || (r_state == S_CSUM);
        end
    end

    assign w_accept    = in_valid & in_ready;
    assign w_len       = {r_len[15:8], in_byte};
    assign w_last_word = (16'(r_wcnt) + 16'd1) == r_len;
    // Lanes 3..1 already hold the first three bytes when the 4th arrives.
    assign w_word      = {r_word[31:8], in_byte};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_HDR0;
            r_len     <= '0;
            r_xor     <= '0;
            r_wcnt    <= '0;
            r_bcnt    <= '0;
            r_word    <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_HDR0: begin
                    if (w_accept) begin
                        r_len[15:8] <= in_byte;
                        r_xor       <= r_xor ^ in_byte;
                        r_state     <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (w_accept) begin
                        r_len <= w_len;
                        r_xor <= r_xor ^ in_byte;
                        if (w_len > DEPTH_16) begin
                            r_error <= 1'b1;
                            r_state <= S_ERROR;
                        end else if (w_len == 16'd0) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_xor  <= r_xor ^ in_byte;
                        r_bcnt <= r_bcnt + 2'd1;
                        case (r_bcnt)
                            2'd0: r_word[31:24] <= in_byte;
                            2'd1: r_word[23:16] <= in_byte;
                            2'd2: r_word[15:8]  <= in_byte;
                            default: begin
                                r_word[7:0] <= in_byte;
                                r_we        <= 1'b1;
                                r_addr      <= r_wcnt[ADDR_W-1:0];
                                r_wdata     <= w_word;
                                r_wcnt      <= r_wcnt + 1'b1;
                                if (w_last_word) begin
                                    r_state <= S_CSUM;
                                end
                            end
                        endcase
                    end
                end
                S_CSUM: begin
                    if (w_accept) begin
                        if (in_byte == r_xor) begin
                            r_done    <= 1'b1;
                            r_cpu_rst <= 1'b0;
                            r_state   <= S_DONE;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= S_ERROR;
                        end
                    end
                end
                default: begin
                    // DONE or ERROR: only reload leaves; XOR is cleared on HDR0 entry.
                    if (reload) begin
                        r_done    <= 1'b0;
                        r_error   <= 1'b0;
                        r_cpu_rst <= 1'b1;
                        r_wcnt    <= '0;
                        r_bcnt    <= '0;
                        r_xor     <= '0;
                        r_state   <= S_HDR0;
                    end
                end
            endcase
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: scoreboard of expected memory writes, pushed
// when a stream is built and popped when imem_we is observed.
module tb_program_loader;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              error;

    program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];   // {addr, data}

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Write monitor: every observed write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            $display("[TB] write addr=%0d data=%h", imem_addr, imem_wdata);
            if (exp_q.size() == 0) begin
                chk("unexpected_we", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("we_addr", 32'(imem_addr), e[63:32]);
                chk("we_data", imem_wdata, e[31:0]);
            end
        end
    end

    // Drives bytes at negedges; a byte is counted sent when in_ready is high
    // before the following posedge. Returns at the negedge after the last accept.
    task automatic send(input logic [7:0] s[$], input bit gaps);
        int i;
        int budget;
        i = 0;
        budget = 0;
        while (i < s.size()) begin
            @(negedge clk);
            budget++;
            if (budget > 20000) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom);
            end else begin
                if (in_ready !== 1'b1) begin
                    chk("send_ready", 32'(in_ready), 32'd1);
                    break;
                end
                in_valid = 1'b1;
                in_byte  = s[i];
                i++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_reload(input string tag);
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk({tag, "_done"},    32'(done),     32'd0);
        chk({tag, "_error"},   32'(error),    32'd0);
        chk({tag, "_cpu_rst"}, 32'(cpu_rst),  32'd1);
        chk({tag, "_ready"},   32'(in_ready), 32'd1);
    endtask

    task automatic push_nominal();
        exp_q.push_back({32'd0, 32'h84010400});
        exp_q.push_back({32'd1, 32'h84020006});
    endtask

    task automatic chk_final(input string tag, input logic d, input logic e, input logic cr);
        chk({tag, "_done"},    32'(done),     32'(d));
        chk({tag, "_error"},   32'(error),    32'(e));
        chk({tag, "_cpu_rst"}, 32'(cpu_rst),  32'(cr));
        chk({tag, "_ready"},   32'(in_ready), 32'd0);
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] nom[$];
        logic [7:0] s[$];
        logic [7:0] x;
        logic [31:0] w;

        nom = '{8'h00, 8'h02, 8'h84, 8'h01, 8'h04, 8'h00, 8'h84, 8'h02, 8'h00, 8'h06, 8'h03};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        reload   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready",   32'(in_ready),  32'd0);
        chk("rst_we",      32'(imem_we),   32'd0);
        chk("rst_addr",    32'(imem_addr), 32'd0);
        chk("rst_wdata",   imem_wdata,     32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst),   32'd1);
        chk("rst_done",    32'(done),      32'd0);
        chk("rst_error",   32'(error),     32'd0);
        rst = 1'b0;
        #1;
        chk("idle_ready",  32'(in_ready),  32'd1);

        // Nominal load, in_valid held high.
        push_nominal();
        send(nom, 1'b0);
        chk_final("nom", 1'b1, 1'b0, 1'b0);
        pulse_reload("nom_reload");

        // Same stream with random valid gaps.
        push_nominal();
        send(nom, 1'b1);
        chk_final("gaps", 1'b1, 1'b0, 1'b0);
        pulse_reload("gaps_reload");

        // Bad checksum: both writes still happen.
        push_nominal();
        s = nom;
        s[10] = 8'h04;
        send(s, 1'b0);
        chk_final("badcs", 1'b0, 1'b1, 1'b1);
        pulse_reload("badcs_reload");

        // Oversized length: N = 1025, no writes.
        s = '{8'h04, 8'h01};
        send(s, 1'b0);
        chk_final("oversize", 1'b0, 1'b1, 1'b1);
        pulse_reload("oversize_reload");

        // Empty image.
        s = '{8'h00, 8'h00, 8'h00};
        send(s, 1'b0);
        chk_final("empty", 1'b1, 1'b0, 1'b0);
        pulse_reload("empty_reload");

        // Full-depth image: N == DEPTH is legal and must not wrap.
        s = '{8'h04, 8'h00};
        x = 8'h04;
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            exp_q.push_back({32'(i), w});
            for (int b = 3; b >= 0; b--) begin
                s.push_back(w[8*b +: 8]);
                x = x ^ w[8*b +: 8];
            end
        end
        s.push_back(x);
        send(s, 1'b0);
        chk_final("full", 1'b1, 1'b0, 1'b0);
        pulse_reload("full_reload");

        // Mid-load reset after 6 bytes (word 0 already written).
        exp_q.push_back({32'd0, 32'h84010400});
        s = nom[0:5];
        send(s, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_ready",   32'(in_ready),  32'd0);
        chk("mid_we",      32'(imem_we),   32'd0);
        chk("mid_addr",    32'(imem_addr), 32'd0);
        chk("mid_wdata",   imem_wdata,     32'd0);
        chk("mid_cpu_rst", 32'(cpu_rst),   32'd1);
        chk("mid_done",    32'(done),      32'd0);
        chk("mid_error",   32'(error),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        push_nominal();
        send(nom, 1'b0);
        chk_final("resend", 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
